fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_fetch_pc_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PC width, reset PC and fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned PC_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FLUSH_CNT_W = 3;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [PC_W-1:0] PC_ONE = 16'h0001;
  localparam logic [CNT_W-1:0] CNT_ONE = 16'h0001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import cpu_pkg::*;
(
  input  logic             clk_pi,
  input  logic             reset_pi,
  input  logic             inc_en_pi,
  output logic [CNT_W-1:0] count_po
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      count_reg <= '0;
    end else if (inc_en_pi && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_ONE;
    end
  end

  assign count_po = count_reg;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer with branch/jump redirect and IF/ID flush generation.
// Define BRANCH_STATS_EN to add saturating taken/not-taken branch counters.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk_pi,
  input  logic            reset_pi,
  input  logic            stall_pi,
  input  logic            branch_valid_pi,
  input  logic            is_branch_taken_pi,
  input  logic [PC_W-1:0] branch_target_pi,
  input  logic            jump_pi,
  input  logic [PC_W-1:0] jump_target_pi,
  input  logic            imem_ready_pi,
  output logic            imem_req_po,
  output logic [PC_W-1:0] pc_po,
  output logic            fetch_valid_po,
  output logic            flush_po
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_count_po,
  output logic [CNT_W-1:0] not_taken_count_po
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE  = 3'd1;

  fetch_state_e           state_reg;
  logic [PC_W-1:0]        pc_reg;
  logic [FLUSH_CNT_W-1:0] flush_cnt_reg;
  logic                   fetch_valid_reg;

  logic            branch_taken;
  logic            redirect;
  logic            accept;
  logic [PC_W-1:0] redirect_target;

  // The branch belongs to the older instruction, so it beats a same-cycle jump.
  assign branch_taken    = branch_valid_pi & is_branch_taken_pi;
  assign redirect        = (branch_taken | jump_pi) & (state_reg != IDLE);
  assign redirect_target = branch_taken ? branch_target_pi : jump_target_pi;

  assign imem_req_po    = (state_reg != IDLE) & ~stall_pi;
  assign accept         = imem_req_po & imem_ready_pi;
  assign flush_po       = (flush_cnt_reg != '0);
  assign fetch_valid_po = fetch_valid_reg & ~flush_po;
  assign pc_po          = pc_reg;

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      flush_cnt_reg   <= '0;
      fetch_valid_reg <= 1'b0;
    end else begin
      // A fetch issued alongside a redirect is on the wrong path.
      fetch_valid_reg <= accept & ~redirect;
      case (state_reg)
        IDLE: begin
          state_reg <= FETCH;
        end
        default: begin
          if (redirect) begin
            pc_reg        <= redirect_target;
            flush_cnt_reg <= FLUSH_LOAD;
            state_reg     <= REDIRECT;
          end else begin
            if (accept) begin
              pc_reg <= pc_reg + PC_ONE;
            end
            // Stall freezes the flush window so it covers the real pipeline slots.
            if ((state_reg == REDIRECT) && !stall_pi) begin
              flush_cnt_reg <= flush_cnt_reg - FLUSH_ONE;
              if (flush_cnt_reg == FLUSH_ONE) begin
                state_reg <= FETCH;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  sat_counter u_taken_count (
    .clk_pi    (clk_pi),
    .reset_pi  (reset_pi),
    .inc_en_pi (branch_valid_pi & is_branch_taken_pi),
    .count_po  (taken_count_po)
  );

  sat_counter u_not_taken_count (
    .clk_pi    (clk_pi),
    .reset_pi  (reset_pi),
    .inc_en_pi (branch_valid_pi & ~is_branch_taken_pi),
    .count_po  (not_taken_count_po)
  );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; branch counter checks run when BRANCH_STATS_EN is defined.
module tb_fetch_pc_unit;

  logic        clk_pi = 1'b0;
  logic        reset_pi;
  logic        stall_pi;
  logic        branch_valid_pi;
  logic        is_branch_taken_pi;
  logic [15:0] branch_target_pi;
  logic        jump_pi;
  logic [15:0] jump_target_pi;
  logic        imem_ready_pi;
  logic        imem_req_po;
  logic [15:0] pc_po;
  logic        fetch_valid_po;
  logic        flush_po;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count_po;
  logic [15:0] not_taken_count_po;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_pi = ~clk_pi;

  fetch_pc_unit #(
    .RESET_PC     (16'h0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk_pi             (clk_pi),
    .reset_pi           (reset_pi),
    .stall_pi           (stall_pi),
    .branch_valid_pi    (branch_valid_pi),
    .is_branch_taken_pi (is_branch_taken_pi),
    .branch_target_pi   (branch_target_pi),
    .jump_pi            (jump_pi),
    .jump_target_pi     (jump_target_pi),
    .imem_ready_pi      (imem_ready_pi),
    .imem_req_po        (imem_req_po),
    .pc_po              (pc_po),
    .fetch_valid_po     (fetch_valid_po),
    .flush_po           (flush_po)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count_po     (taken_count_po),
    .not_taken_count_po (not_taken_count_po)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk_pi);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_ctl();
    branch_valid_pi    = 1'b0;
    is_branch_taken_pi = 1'b0;
    jump_pi            = 1'b0;
  endtask

  task automatic do_branch(input logic taken, input logic [15:0] target);
    branch_valid_pi    = 1'b1;
    is_branch_taken_pi = taken;
    branch_target_pi   = target;
    tick();
    clear_ctl();
    settle();
  endtask

  initial begin
    reset_pi           = 1'b1;
    stall_pi           = 1'b0;
    branch_valid_pi    = 1'b0;
    is_branch_taken_pi = 1'b0;
    branch_target_pi   = 16'h0000;
    jump_pi            = 1'b0;
    jump_target_pi     = 16'h0000;
    imem_ready_pi      = 1'b1;
    repeat (2) tick();
    chk("rst_pc", pc_po, 16'h0000);
    chk("rst_req", imem_req_po, 1'b0);
    chk("rst_fv", fetch_valid_po, 1'b0);
    chk("rst_flush", flush_po, 1'b0);

    // Reset release: IDLE cycle, then sequential fetch.
    reset_pi = 1'b0;
    settle();
    chk("idle_pc", pc_po, 16'h0000);
    chk("idle_req", imem_req_po, 1'b0);
    tick(); settle();
    chk("fetch0_pc", pc_po, 16'h0000);
    chk("fetch0_req", imem_req_po, 1'b1);
    chk("fetch0_fv", fetch_valid_po, 1'b0);
    tick(); settle();
    chk("fetch1_pc", pc_po, 16'h0001);
    chk("fetch1_fv", fetch_valid_po, 1'b1);
    tick(); settle();
    chk("fetch2_pc", pc_po, 16'h0002);
    repeat (14) tick();
    settle();
    chk("seq_pc10", pc_po, 16'h0010);

    // Taken branch at 0010 -> 0040 with a two-cycle flush.
    do_branch(1'b1, 16'h0040);
    chk("br_pc", pc_po, 16'h0040);
    chk("br_flush1", flush_po, 1'b1);
    chk("br_fv1", fetch_valid_po, 1'b0);
    tick(); settle();
    chk("br_pc41", pc_po, 16'h0041);
    chk("br_flush2", flush_po, 1'b1);
    chk("br_fv2", fetch_valid_po, 1'b0);
    tick(); settle();
    chk("br_pc42", pc_po, 16'h0042);
    chk("br_flush_end", flush_po, 1'b0);
    chk("br_fv_back", fetch_valid_po, 1'b1);

    // Not-taken branch sequences normally.
    do_branch(1'b0, 16'h0123);
    chk("nt_pc", pc_po, 16'h0043);
    chk("nt_flush", flush_po, 1'b0);

    // Branch and jump together: branch wins; jump during flush restarts it.
    jump_pi = 1'b1;
    jump_target_pi = 16'h0100;
    do_branch(1'b1, 16'h0080);
    chk("prio_pc", pc_po, 16'h0080);
    chk("prio_flush", flush_po, 1'b1);
    jump_pi = 1'b1;
    jump_target_pi = 16'h0200;
    tick(); clear_ctl(); settle();
    chk("rejump_pc", pc_po, 16'h0200);
    chk("rejump_flush1", flush_po, 1'b1);
    tick(); settle();
    chk("rejump_pc201", pc_po, 16'h0201);
    chk("rejump_flush2", flush_po, 1'b1);
    tick(); settle();
    chk("rejump_pc202", pc_po, 16'h0202);
    chk("rejump_flush_end", flush_po, 1'b0);

    // Memory not ready: PC held with request asserted.
    imem_ready_pi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("nrdy_req", imem_req_po, 1'b1);
      chk("nrdy_pc", pc_po, 16'h0202);
      tick();
    end
    chk("nrdy_fv", fetch_valid_po, 1'b0);
    stall_pi = 1'b1;
    settle();
    chk("stall_req", imem_req_po, 1'b0);
    imem_ready_pi = 1'b1;
    tick(); settle();
    chk("stall_pc", pc_po, 16'h0202);
    stall_pi = 1'b0;
    tick(); settle();
    chk("resume_pc", pc_po, 16'h0203);
    chk("resume_fv", fetch_valid_po, 1'b1);

    // Wrap from FFFF to 0000 without a flush.
    jump_pi = 1'b1;
    jump_target_pi = 16'hFFFC;
    tick(); clear_ctl();
    repeat (2) tick();
    settle();
    chk("wrap_pre_pc", pc_po, 16'hFFFE);
    tick(); settle();
    chk("wrap_ffff", pc_po, 16'hFFFF);
    tick(); settle();
    chk("wrap_pc", pc_po, 16'h0000);
    chk("wrap_flush", flush_po, 1'b0);

    // Redirect under stall still loads; flush count frozen while stalled.
    stall_pi = 1'b1;
    jump_pi = 1'b1;
    jump_target_pi = 16'h0300;
    tick(); clear_ctl(); settle();
    chk("stjmp_pc", pc_po, 16'h0300);
    repeat (2) tick();
    settle();
    chk("stjmp_hold_pc", pc_po, 16'h0300);
    chk("stjmp_hold_flush", flush_po, 1'b1);
    stall_pi = 1'b0;
    tick(); settle();
    chk("stjmp_pc301", pc_po, 16'h0301);
    chk("stjmp_flush_last", flush_po, 1'b1);
    tick(); settle();
    chk("stjmp_pc302", pc_po, 16'h0302);
    chk("stjmp_flush_end", flush_po, 1'b0);

    // Asynchronous reset in the middle of a redirect.
    jump_pi = 1'b1;
    jump_target_pi = 16'h0400;
    tick(); clear_ctl(); settle();
    chk("pre_rst_flush", flush_po, 1'b1);
    reset_pi = 1'b1;
    settle();
    chk("arst_pc", pc_po, 16'h0000);
    chk("arst_flush", flush_po, 1'b0);
    chk("arst_req", imem_req_po, 1'b0);
    chk("arst_fv", fetch_valid_po, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("arst_taken", taken_count_po, 16'h0000);
    chk("arst_ntaken", not_taken_count_po, 16'h0000);
`endif
    tick();
    reset_pi = 1'b0;
    settle();
    chk("post_rst_idle_req", imem_req_po, 1'b0);
    tick(); settle();
    chk("post_rst_pc", pc_po, 16'h0000);
    chk("post_rst_flush", flush_po, 1'b0);

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 5; i++) begin
      do_branch(i < 3, 16'h0500);
    end
    chk("stats_taken", taken_count_po, 16'd3);
    chk("stats_ntaken", not_taken_count_po, 16'd2);
    jump_pi = 1'b1;
    tick(); clear_ctl(); settle();
    chk("stats_jump_ignored", taken_count_po, 16'd3);
    branch_valid_pi = 1'b1;
    is_branch_taken_pi = 1'b1;
    repeat (65532) tick();
    clear_ctl();
    settle();
    chk("stats_sat_reach", taken_count_po, 16'hFFFF);
    do_branch(1'b1, 16'h0600);
    chk("stats_sat_hold", taken_count_po, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
